// File: rtl/bulls_cows_engine.sv
// Bulls-and-Cows game core: collects keypad digits into a guess, then scores it one
// digit per cycle against the loaded secret and tracks tries through WIN / LOSE.
module bulls_cows_engine #(
  parameter int DIGITS       = 4,
  parameter int MAX_TRIES    = 10,
  parameter int TRY_W        = 4,
  parameter int ALLOW_REPEAT = 0,
  localparam int CW          = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] secret_in,
  input  logic                secret_load,
  input  logic                key_valid,
  input  logic [3:0]          key_digit,
  input  logic                key_clear,
  input  logic                key_enter,
  output logic [4*DIGITS-1:0] guess,
  output logic [CW-1:0]       guess_len,
  output logic                busy,
  output logic                result_valid,
  output logic [CW-1:0]       strike,
  output logic [CW-1:0]       ball,
  output logic                err_dup,
  output logic [TRY_W-1:0]    tries,
  output logic                win,
  output logic                lose
);

  typedef enum logic [2:0] {IDLE, ENTRY, SCORE, WIN, LOSE} state_t;

  state_t              state, state_d;
  logic [4*DIGITS-1:0] secret;
  logic [CW-1:0]       idx;
  logic [CW-1:0]       st_acc, bl_acc;
  logic                dup_acc;
  logic [DIGITS-1:0]   lane_st, lane_bl, lane_dup;
  logic                cur_st, cur_bl, cur_dup;
  logic                full, score_done, reject;

  assign full       = (guess_len == CW'(DIGITS));
  assign score_done = (idx == CW'(DIGITS));
  assign reject     = dup_acc && (ALLOW_REPEAT == 0);
  assign busy       = (state == SCORE);
  assign win        = (state == WIN);
  assign lose       = (state == LOSE);

  // Per-position match flags; SCORE walks idx across them one lane per cycle.
  always_comb begin
    lane_st  = '0;
    lane_bl  = '0;
    lane_dup = '0;
    for (int i = 0; i < DIGITS; i++) begin
      lane_st[i] = (guess[4*i +: 4] == secret[4*i +: 4]);
      for (int j = 0; j < DIGITS; j++) begin
        if (j != i && guess[4*i +: 4] == secret[4*j +: 4]) lane_bl[i] = 1'b1;
        if (j > i && guess[4*i +: 4] == guess[4*j +: 4])   lane_dup[i] = 1'b1;
      end
      if (lane_st[i]) lane_bl[i] = 1'b0;
    end
  end

  always_comb begin
    cur_st  = 1'b0;
    cur_bl  = 1'b0;
    cur_dup = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == CW'(i)) begin
        cur_st  = lane_st[i];
        cur_bl  = lane_bl[i];
        cur_dup = lane_dup[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (secret_load) begin
      state_d = ENTRY;
    end else begin
      case (state)
        ENTRY: if (!key_clear && key_enter && full) state_d = SCORE;
        SCORE: begin
          if (score_done) begin
            if (reject)                                         state_d = ENTRY;
            else if (st_acc == CW'(DIGITS))                     state_d = WIN;
            else if ((tries + TRY_W'(1)) == TRY_W'(MAX_TRIES))  state_d = LOSE;
            else                                                state_d = ENTRY;
          end
        end
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      secret       <= '0;
      guess        <= '0;
      guess_len    <= '0;
      strike       <= '0;
      ball         <= '0;
      tries        <= '0;
      result_valid <= 1'b0;
      err_dup      <= 1'b0;
      idx          <= '0;
      st_acc       <= '0;
      bl_acc       <= '0;
      dup_acc      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      err_dup      <= 1'b0;
      if (secret_load) begin
        secret    <= secret_in;
        guess     <= '0;
        guess_len <= '0;
        tries     <= '0;
        strike    <= '0;
        ball      <= '0;
        idx       <= '0;
      end else begin
        case (state)
          ENTRY: begin
            if (key_clear) begin
              guess     <= '0;
              guess_len <= '0;
            end else if (key_enter && full) begin
              idx     <= '0;
              st_acc  <= '0;
              bl_acc  <= '0;
              dup_acc <= 1'b0;
            end else if (key_valid && key_digit <= 4'd9 && !full) begin
              guess     <= {guess[4*DIGITS-5:0], key_digit};
              guess_len <= guess_len + CW'(1);
            end
          end
          SCORE: begin
            if (!score_done) begin
              st_acc  <= st_acc + CW'(cur_st);
              bl_acc  <= bl_acc + CW'(cur_bl);
              dup_acc <= dup_acc | cur_dup;
              idx     <= idx + CW'(1);
            end else begin
              // A rejected guess leaves the held score and try count untouched.
              if (reject) begin
                err_dup <= 1'b1;
              end else begin
                result_valid <= 1'b1;
                strike       <= st_acc;
                ball         <= bl_acc;
                tries        <= tries + TRY_W'(1);
              end
              guess     <= '0;
              guess_len <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
